i2s_axis_transmitter: RTL and testbench

- Playback-direction counterpart of the I2S receiver.
- Accepts tagged audio samples on an AXI4-Stream slave, buffers them in a small FIFO, and serialises them as a standard Philips I2S master: it generates bclk and lrclk and drives sdata.
- Sits between a DMA/AXIS source and an external DAC, or loops back into the I2S receiver under test.

---
 rtl/i2s_axis_transmitter.sv | 135 +++++++++++++
 tb/tb_i2s_axis_transmitter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_axis_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : i2s_axis_transmitter
// Description : AXI4-Stream to Philips I2S master transmitter with sample FIFO.
//               Generates bclk/lrclk and shifts channel-tagged samples MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_axis_transmitter #(
    parameter int I2S_DATA_BIT_WIDTH     = 24,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int BCLK_DIV               = 4,
    parameter int FIFO_DEPTH             = 8
) (
    input  logic                              i2s_sender_clk,
    input  logic                              i2s_sender_rst,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic                              s00_axis_tlast,
    output logic                              i2s_sender_bclk,
    output logic                              i2s_sender_lrclk,
    output logic                              i2s_sender_sdata,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              underrun,
    output logic                              sync_error
);

    localparam int c_w     = I2S_DATA_BIT_WIDTH;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_div_w = $clog2(BCLK_DIV);

    localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(BCLK_DIV - 1);
    localparam logic [c_ptr_w:0]   c_fifo_full = (c_ptr_w + 1)'(FIFO_DEPTH);

    // Each entry holds {channel, sample}
    logic [c_w:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_div_w-1:0]   r_div_cnt;
    logic [5:0]           r_bit_cnt;
    logic [c_w-1:0]       r_shift;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_fe;
    logic [5:0]           w_bit_next;
    logic                 w_slot_start;
    logic                 w_slot_ch;
    logic [c_w:0]         w_head;
    logic                 w_empty;
    logic                 w_head_match;
    logic [c_ptr_w:0]     w_count_next;
    logic                 w_unused;

    assign w_unused     = &{1'b0, s00_axis_tlast, s00_axis_tdata};

    assign w_push       = s00_axis_tvalid & s00_axis_tready;
    assign w_fe         = (r_div_cnt == c_div_last) & i2s_sender_bclk;
    assign w_bit_next   = r_bit_cnt + 6'd1;
    assign w_slot_start = w_fe & (w_bit_next[4:0] == 5'd0);
    assign w_slot_ch    = w_bit_next[5];
    assign w_head       = r_mem[r_rd_ptr];
    assign w_empty      = (fifo_count == '0);
    assign w_head_match = (w_head[c_w] == w_slot_ch);
    // A push landing on a slot-start edge is not yet counted, so it cannot be popped here
    assign w_pop        = w_slot_start & ~w_empty & w_head_match;

    always_comb begin
        w_count_next = fifo_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = fifo_count + (c_ptr_w + 1)'(1);
            2'b01:   w_count_next = fifo_count - (c_ptr_w + 1)'(1);
            default: w_count_next = fifo_count;
        endcase
    end

    always_ff @(posedge i2s_sender_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s00_axis_tdata[c_w:0];
        end
    end

    always_ff @(posedge i2s_sender_clk or posedge i2s_sender_rst) begin
        if (i2s_sender_rst) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            fifo_count       <= '0;
            s00_axis_tready  <= 1'b0;
            r_div_cnt        <= '0;
            i2s_sender_bclk  <= 1'b1;
            r_bit_cnt        <= 6'd63;
            i2s_sender_lrclk <= 1'b1;
            i2s_sender_sdata <= 1'b0;
            r_shift          <= '0;
            underrun         <= 1'b0;
            sync_error       <= 1'b0;
        end else begin
            underrun   <= 1'b0;
            sync_error <= 1'b0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            fifo_count      <= w_count_next;
            s00_axis_tready <= (w_count_next != c_fifo_full);

            if (r_div_cnt == c_div_last) begin
                r_div_cnt       <= '0;
                i2s_sender_bclk <= ~i2s_sender_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + c_div_w'(1);
            end

            // Everything serial moves on the bclk falling edge; the DAC samples on the rise
            if (w_fe) begin
                r_bit_cnt        <= w_bit_next;
                i2s_sender_lrclk <= w_bit_next[5];
                if (w_slot_start) begin
                    i2s_sender_sdata <= 1'b0;
                    r_shift          <= w_pop ? w_head[c_w-1:0] : '0;
                    underrun         <= w_empty;
                    sync_error       <= ~w_empty & ~w_head_match;
                end else begin
                    i2s_sender_sdata <= r_shift[c_w-1];
                    r_shift          <= {r_shift[c_w-2:0], 1'b0};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_axis_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_axis_transmitter
// Description : Directed self-checking bench for i2s_axis_transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_axis_transmitter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [3:0]  count;
    logic        ur_pulse;
    logic        se_pulse;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i2s_axis_transmitter #(
        .I2S_DATA_BIT_WIDTH     (24),
        .C_S00_AXIS_TDATA_WIDTH (32),
        .BCLK_DIV               (4),
        .FIFO_DEPTH             (8)
    ) dut (
        .i2s_sender_clk   (clk),
        .i2s_sender_rst   (rst),
        .s00_axis_tdata   (tdata),
        .s00_axis_tvalid  (tvalid),
        .s00_axis_tready  (tready),
        .s00_axis_tlast   (tlast),
        .i2s_sender_bclk  (bclk),
        .i2s_sender_lrclk (lrclk),
        .i2s_sender_sdata (sdata),
        .fifo_count       (count),
        .underrun         (ur_pulse),
        .sync_error       (se_pulse)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds a word on the bus until accepted; returns the number of stalled cycles
    task automatic push(input logic ch, input logic [23:0] smp, output int waits);
        tdata  = {7'd0, ch, smp};
        tvalid = 1'b1;
        tlast  = ch;
        waits  = 0;
        while (tready !== 1'b1 && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        if (tready !== 1'b1) check("push_timeout", {63'd0, tready}, 64'd1);
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    // Starts at the negedge right after a left-slot falling edge; captures one frame
    task automatic capture(output logic [63:0] sd, output logic [63:0] lr,
                           output int ur, output int se);
        sd = '0;
        lr = '0;
        ur = 0;
        se = 0;
        for (int k = 0; k < 64; k++) begin
            ur += int'(ur_pulse);
            se += int'(se_pulse);
            tick(6);
            sd = {sd[62:0], sdata};
            lr = {lr[62:0], lrclk};
            tick(2);
        end
    endtask

    localparam logic [63:0] c_lr_frame = {32'h0000_0000, 32'hFFFF_FFFF};

    initial begin
        logic [63:0] sd;
        logic [63:0] lr;
        int          ur;
        int          se;
        int          waits;

        rst    = 1'b1;
        tdata  = '0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tick(3);
        check("rst_bclk",   {63'd0, bclk},     64'd1);
        check("rst_lrclk",  {63'd0, lrclk},    64'd1);
        check("rst_sdata",  {63'd0, sdata},    64'd0);
        check("rst_tready", {63'd0, tready},   64'd0);
        check("rst_count",  {60'd0, count},    64'd0);
        check("rst_ur",     {63'd0, ur_pulse}, 64'd0);
        check("rst_se",     {63'd0, se_pulse}, 64'd0);

        // Basic L/R frame
        rst = 1'b0;
        tick(1);
        check("tready_after_release", {63'd0, tready}, 64'd1);
        check("bclk_before_fe",       {63'd0, bclk},   64'd1);
        push(1'b0, 24'hABCDEF, waits);
        push(1'b1, 24'h123456, waits);
        check("count_two", {60'd0, count}, 64'd2);
        tick(1);
        check("first_fe_bclk",  {63'd0, bclk},  64'd0);
        check("first_fe_lrclk", {63'd0, lrclk}, 64'd0);
        check("first_fe_count", {60'd0, count}, 64'd1);
        capture(sd, lr, ur, se);
        check("f1_sdata", sd, {32'h55E6_F780, 32'h091A_2B00});
        check("f1_lrclk", lr, c_lr_frame);
        check("f1_ur",    64'(ur), 64'd0);
        check("f1_se",    64'(se), 64'd0);

        // Idle frame: underrun on every slot
        capture(sd, lr, ur, se);
        check("idle_sdata",  sd, 64'd0);
        check("idle_lrclk",  lr, c_lr_frame);
        check("idle_ur",     64'(ur), 64'd2);
        check("idle_se",     64'(se), 64'd0);
        check("idle_tready", {63'd0, tready}, 64'd1);
        check("idle_count",  {60'd0, count},  64'd0);

        // Back-pressure: ten words, alternating channels starting with right
        for (int i = 0; i < 8; i++) begin
            push(1'(i % 2 == 0), {16'hC3A5, 8'(i)}, waits);
            check("fill_wait", 64'(waits), 64'd0);
        end
        check("full_count",  {60'd0, count},  64'd8);
        check("full_tready", {63'd0, tready}, 64'd0);
        push(1'b1, {16'hC3A5, 8'd8}, waits);
        check("stall_w8",    64'(waits), 64'd248);
        push(1'b0, {16'hC3A5, 8'd9}, waits);
        check("stall_w9",    64'(waits), 64'd255);
        check("refill_count", {60'd0, count}, 64'd8);
        tick(511);
        capture(sd, lr, ur, se);
        check("bp_sdata", sd, {1'b0, 24'hC3A503, 7'd0, 1'b0, 24'hC3A504, 7'd0});
        check("bp_ur",    64'(ur), 64'd0);
        check("bp_se",    64'(se), 64'd0);
        check("bp_count", {60'd0, count}, 64'd4);
        tick(1024);
        check("drain_count", {60'd0, count}, 64'd0);
        check("drain_se",    {63'd0, se_pulse}, 64'd0);
        check("drain_ur",    {63'd0, ur_pulse}, 64'd0);

        // Misaligned first word
        tick(256);
        check("right_empty_ur", {63'd0, ur_pulse}, 64'd1);
        push(1'b1, 24'h0F1E2D, waits);
        push(1'b0, 24'h3C4B5A, waits);
        push(1'b1, 24'h697887, waits);
        tick(253);
        check("mis_se_pulse", {63'd0, se_pulse}, 64'd1);
        check("mis_count",    {60'd0, count},    64'd3);
        capture(sd, lr, ur, se);
        check("mis_sdata", sd, {32'd0, 1'b0, 24'h0F1E2D, 7'd0});
        check("mis_se",    64'(se), 64'd1);
        check("mis_ur",    64'(ur), 64'd0);
        capture(sd, lr, ur, se);
        check("resync_sdata", sd, {1'b0, 24'h3C4B5A, 7'd0, 1'b0, 24'h697887, 7'd0});
        check("resync_se",    64'(se), 64'd0);
        check("resync_ur",    64'(ur), 64'd0);
        check("resync_end_ur", {63'd0, ur_pulse}, 64'd1);

        // Push coinciding with a left slot start on an empty FIFO
        tick(511);
        tdata  = {7'd0, 1'b0, 24'h5A5A5A};
        tvalid = 1'b1;
        tick(1);
        tvalid = 1'b0;
        check("race_ur",    {63'd0, ur_pulse}, 64'd1);
        check("race_count", {60'd0, count},    64'd1);
        check("race_lrclk", {63'd0, lrclk},    64'd0);
        capture(sd, lr, ur, se);
        check("race_sdata", sd, 64'd0);
        check("race_ur_n",  64'(ur), 64'd1);
        check("race_se_n",  64'(se), 64'd1);
        check("race_pop_count", {60'd0, count}, 64'd0);

        // Reset in the middle of a left slot at bit 10
        push(1'b1, 24'h111111, waits);
        tick(79);
        check("mid_sdata", {63'd0, sdata}, 64'd1);
        check("mid_lrclk", {63'd0, lrclk}, 64'd0);
        check("mid_count", {60'd0, count}, 64'd1);
        rst = 1'b1;
        #1;
        check("arst_bclk",   {63'd0, bclk},   64'd1);
        check("arst_lrclk",  {63'd0, lrclk},  64'd1);
        check("arst_sdata",  {63'd0, sdata},  64'd0);
        check("arst_tready", {63'd0, tready}, 64'd0);
        check("arst_count",  {60'd0, count},  64'd0);
        tick(2);
        rst = 1'b0;
        tick(3);
        check("rel_bclk",   {63'd0, bclk},   64'd1);
        check("rel_lrclk",  {63'd0, lrclk},  64'd1);
        check("rel_tready", {63'd0, tready}, 64'd1);
        tick(1);
        check("rel_fe_bclk",  {63'd0, bclk},     64'd0);
        check("rel_fe_lrclk", {63'd0, lrclk},    64'd0);
        check("rel_fe_ur",    {63'd0, ur_pulse}, 64'd1);
        check("rel_fe_count", {60'd0, count},    64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
